uart_frame_tx: RTL and testbench

//  UART transmit side of the host<->FPGA command link. It buffers a payload, then sends one framed message:
//  SOF byte 0x00, then payload bytes, then EOF byte 0xFF. This is the same framing the OLED controller parses on Rx.

---
 rtl/uart_frame_tx_if.sv | 21 ++
 rtl/uart_frame_tx.sv | 141 ++++++++++++++
 tb/tb_uart_frame_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// Payload-write, start and status signals of the framed UART transmitter.
interface uart_frame_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic       Tx;
  logic       busy;
  logic       done;
  logic       wr_rej;
  logic [7:0] count;

  modport master (
    output wr_en, wr_data, start,
    input  Tx, busy, done, wr_rej, count
  );

  modport slave (
    input  wr_en, wr_data, start,
    output Tx, busy, done, wr_rej, count
  );
endinterface

// File: rtl/uart_frame_tx.sv
// Buffers payload bytes and sends them as one 8N1 frame: 0x00, payload, 0xFF.
module uart_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned MAX_LEN      = 31
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  uart_frame_tx_if.slave bus
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    LEN_MAX   = 8'(MAX_LEN);
  localparam logic [3:0]    STOP_BIT  = 4'd9;

  typedef enum logic [1:0] {IDLE, SOF, PAYLOAD, EOF} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [IW-1:0] index_q, index_d;
  logic [7:0]    count_q, count_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rej_q, rej_d;
  logic          wr_ok_c;
  logic [7:0]    cur_byte_c;
  logic [7:0]    pay_q [MAX_LEN];

  // Next-state logic: write acceptance in IDLE, bit/byte sequencing while framing
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    index_d    = index_q;
    count_d    = count_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rej_d      = 1'b0;
    wr_ok_c    = 1'b0;
    cur_byte_c = 8'hFF;

    if (state_q == SOF)          cur_byte_c = 8'h00;
    else if (state_q == PAYLOAD) cur_byte_c = pay_q[AW'(index_q)];

    case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          if ((count_q < LEN_MAX) && (bus.wr_data != 8'h00) && (bus.wr_data != 8'hFF)) begin
            wr_ok_c = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            rej_d = 1'b1;
          end
        end
        // count_d already includes a same-cycle accepted write
        if (bus.start && (count_d != 8'd0)) begin
          state_d = SOF;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          index_d = '0;
        end
      end
      default: begin
        rej_d = bus.wr_en;
        if (baud_q != BAUD_LAST) begin
          baud_d = baud_q + BW'(1);
        end else begin
          baud_d = '0;
          if (bit_q != STOP_BIT) begin
            bit_d = bit_q + 4'd1;
            tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte_c[bit_q[2:0]];
          end else begin
            // Stop bit finished: next start bit follows immediately unless the frame ends
            bit_d = '0;
            tx_d  = 1'b0;
            case (state_q)
              SOF: begin
                state_d = PAYLOAD;
                index_d = '0;
              end
              PAYLOAD: begin
                if (8'(index_q) == (count_q - 8'd1)) state_d = EOF;
                else                                 index_d = index_q + IW'(1);
              end
              default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                count_d = '0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      index_q <= '0;
      count_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      index_q <= index_d;
      count_q <= count_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
    end
  end

  // Payload storage needs no reset; count bounds what is ever read
  always_ff @(posedge CLOCK_50) begin
    if (wr_ok_c) pay_q[AW'(count_q)] <= bus.wr_data;
  end

  assign bus.Tx     = tx_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.wr_rej = rej_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench: expected frame bytes are queued at start; a serial decoder pops and compares.
module tb_uart_frame_tx;
  localparam int CPB = 16;
  localparam int ML  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_tx_if bus ();

  uart_frame_tx #(.CLKS_PER_BIT(CPB), .MAX_LEN(ML)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int frames_expected = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_q[$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endfunction

  // Independent serial decoder: samples mid-bit and scores each completed byte
  bit         rx_busy = 1'b0;
  int         rx_t = 0;
  int         rx_k;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (rst) rx_busy = 1'b0;
    else if (!rx_busy) begin
      if (bus.Tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_t    = 0;
      end
    end else rx_t++;

    if (!rst && rx_busy && ((rx_t % CPB) == CPB / 2)) begin
      rx_k = rx_t / CPB;
      if (rx_k == 0) check("rx_start_bit", 32'(bus.Tx), 32'd0);
      else if (rx_k <= 8) rx_byte[rx_k-1] = bus.Tx;
      else begin
        check("rx_stop_bit", 32'(bus.Tx), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected_byte got %02h want none", rx_byte);
        end else begin
          check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
        rx_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] d);
    bit ok;
    ok = (model_q.size() < ML) && (d != 8'h00) && (d != 8'hFF);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (ok) model_q.push_back(d);
    check("wr_rej", 32'(bus.wr_rej), 32'(!ok));
    check("wr_count", 32'(bus.count), 32'(model_q.size()));
  endtask

  task automatic run_frame(input bit with_wr, input logic [7:0] wd, input bit write_during);
    int n;
    int t;
    if (with_wr) model_q.push_back(wd);
    n = model_q.size();
    exp_q.push_back(8'h00);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    exp_q.push_back(8'hFF);
    frames_expected++;
    bus.start = 1'b1;
    if (with_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = wd;
    end
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_tx_low", 32'(bus.Tx), 32'd0);
    check("start_count", 32'(bus.count), 32'(n));
    t = 0;
    if (write_during) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'($urandom_range(1, 254));
      tick();
      bus.wr_en = 1'b0;
      t = 1;
      check("busy_wr_rej", 32'(bus.wr_rej), 32'd1);
      check("busy_count", 32'(bus.count), 32'(n));
    end
    while (bus.done !== 1'b1 && t < (n + 2) * 10 * CPB + 50) begin
      tick();
      t++;
    end
    check("frame_len", 32'(t), 32'((n + 2) * 10 * CPB));
    check("done_count", 32'(bus.count), 32'd0);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("done_tx", 32'(bus.Tx), 32'd1);
    tick();
    check("done_pulse_width", 32'(bus.done), 32'd0);
    model_q.delete();
  endtask

  initial begin
    int n;
    bit bad;
    logic [7:0] eng [4];
    eng[0] = 8'h45; eng[1] = 8'h4E; eng[2] = 8'h47; eng[3] = 8'h32;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.start = 1'b0;
    repeat (3) tick();
    check("rst_tx", 32'(bus.Tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_rej", 32'(bus.wr_rej), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte frame
    do_write(8'h43);
    run_frame(1'b0, 8'h00, 1'b0);

    // Reserved bytes rejected
    do_write(8'h49);
    do_write(8'h00);
    do_write(8'hFF);
    run_frame(1'b0, 8'h00, 1'b0);

    // Buffer full, then a write while busy
    repeat (5) do_write(8'($urandom_range(1, 254)));
    run_frame(1'b0, 8'h00, 1'b1);

    // Start with empty buffer is ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      if (bus.Tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
      tick();
    end
    check("empty_start_ignored", 32'(bad), 32'd0);
    run_frame(1'b1, 8'h45, 1'b0);

    // Reset in the middle of a frame
    do_write(8'($urandom_range(1, 254)));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx", 32'(bus.Tx), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    tick();
    rst = 1'b0;
    model_q.delete();
    repeat (200) tick();
    check("midrst_no_done", 32'(done_seen), 32'(frames_expected));
    do_write(8'h52);
    run_frame(1'b0, 8'h00, 1'b0);

    // Loopback-style text frame
    foreach (eng[i]) do_write(eng[i]);
    run_frame(1'b0, 8'h00, 1'b0);

    // Randomized frames
    repeat (6) begin
      n = $urandom_range(1, 4);
      repeat (n) begin
        if ($urandom_range(0, 3) == 0) do_write(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
        do_write(8'($urandom_range(1, 254)));
      end
      run_frame(1'b0, 8'h00, 1'($urandom_range(0, 1)));
    end

    repeat (20) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_seen), 32'(frames_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
